// File: rtl/demux_tdm_pkg.sv
// Shared encodings for the 1:4 TDM demultiplexer.
package demux_tdm_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;
    localparam logic [1:0] CH_D = 2'd3;

endpackage

// File: rtl/demultiplexer1_to_4_tdm_sat_counter.sv
// Saturating up-counter used for the framing-error tally.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/demultiplexer1_to_4_tdm.sv
// 1:4 sample demultiplexer: manual select routing or framed 4-slot TDM.
module demultiplexer1_to_4_tdm
    import demux_tdm_pkg::*;
#(
    parameter int W     = 1,
    parameter int ERR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [W-1:0]     i_din,
    input  logic             i_din_valid,
    input  logic             i_frame_sync,
    input  logic             i_auto_mode,
    input  logic             i_s0,
    input  logic             i_s1,
    output logic [W-1:0]     o_a,
    output logic [W-1:0]     o_b,
    output logic [W-1:0]     o_c,
    output logic [W-1:0]     o_d,
    output logic [3:0]       o_ch_valid,
    output logic             o_locked,
    output logic             o_sync_err,
    output logic [ERR_W-1:0] o_err_count
);

    state_t       r_state;
    state_t       w_state_nxt;
    state_t       w_state_cur;
    logic [1:0]   r_slot;
    logic [1:0]   w_slot_nxt;
    logic [1:0]   w_slot_cur;
    logic         r_auto_q;
    logic         w_toggle;
    logic [W-1:0] r_ch [4];
    logic [W-1:0] w_ch_nxt [4];
    logic [W-1:0] r_sh [3];
    logic [W-1:0] w_sh_nxt [3];
    logic [3:0]   r_chv;
    logic [3:0]   w_chv_nxt;
    logic         r_err;
    logic         w_err_nxt;
    logic [1:0]   w_sel;

    assign w_sel    = {i_s1, i_s0};
    assign w_toggle = (i_auto_mode != r_auto_q);

    // A mode change makes this edge start from a clean hunt.
    assign w_state_cur = w_toggle ? ST_HUNT : r_state;
    assign w_slot_cur  = w_toggle ? CH_A : r_slot;

    always_comb begin
        w_state_nxt = r_state;
        w_slot_nxt  = r_slot;
        w_ch_nxt    = r_ch;
        w_sh_nxt    = r_sh;
        w_chv_nxt   = 4'b0000;
        w_err_nxt   = 1'b0;
        if (!i_auto_mode) begin
            w_state_nxt = ST_HUNT;
            w_slot_nxt  = CH_A;
            w_sh_nxt    = '{default: '0};
            if (i_din_valid) begin
                w_ch_nxt[w_sel] = i_din;
                w_chv_nxt       = 4'b0001 << w_sel;
            end
        end else begin
            if (w_toggle) begin
                w_state_nxt = ST_HUNT;
                w_slot_nxt  = CH_A;
                w_sh_nxt    = '{default: '0};
            end
            if (i_din_valid) begin
                if (w_state_cur == ST_HUNT) begin
                    if (i_frame_sync) begin
                        w_sh_nxt[0] = i_din;
                        w_slot_nxt  = CH_B;
                        w_state_nxt = ST_LOCKED;
                    end
                end else if (i_frame_sync) begin
                    w_err_nxt   = (w_slot_cur != CH_A);
                    w_sh_nxt[0] = i_din;
                    w_slot_nxt  = CH_B;
                end else begin
                    unique case (w_slot_cur)
                        CH_A: begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_HUNT;
                        end
                        CH_B: begin
                            w_sh_nxt[1] = i_din;
                            w_slot_nxt  = CH_C;
                        end
                        CH_C: begin
                            w_sh_nxt[2] = i_din;
                            w_slot_nxt  = CH_D;
                        end
                        CH_D: begin
                            w_ch_nxt[0] = r_sh[0];
                            w_ch_nxt[1] = r_sh[1];
                            w_ch_nxt[2] = r_sh[2];
                            w_ch_nxt[3] = i_din;
                            w_chv_nxt   = 4'b1111;
                            w_slot_nxt  = CH_A;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_HUNT;
            r_slot   <= CH_A;
            r_auto_q <= 1'b0;
            r_ch     <= '{default: '0};
            r_sh     <= '{default: '0};
            r_chv    <= 4'b0000;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_slot   <= w_slot_nxt;
            r_auto_q <= i_auto_mode;
            r_ch     <= w_ch_nxt;
            r_sh     <= w_sh_nxt;
            r_chv    <= w_chv_nxt;
            r_err    <= w_err_nxt;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_err_nxt),
        .o_count (o_err_count)
    );

    assign o_a        = r_ch[0];
    assign o_b        = r_ch[1];
    assign o_c        = r_ch[2];
    assign o_d        = r_ch[3];
    assign o_ch_valid = r_chv;
    assign o_locked   = (r_state == ST_LOCKED);
    assign o_sync_err = r_err;

endmodule

// File: tb/tb_demultiplexer1_to_4_tdm.sv
// Directed and random bench for the 1:4 TDM demultiplexer.
module tb_demultiplexer1_to_4_tdm;

    localparam int W     = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     din;
    logic             din_valid;
    logic             frame_sync;
    logic             auto_mode;
    logic             s0;
    logic             s1;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic [W-1:0]     d;
    logic [3:0]       ch_valid;
    logic             locked;
    logic             sync_err;
    logic [ERR_W-1:0] err_count;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [W-1:0] m_out [4];
    logic [3:0]   m_chv;
    logic         m_err;
    int           m_cnt;
    bit           m_locked;
    bit           m_prev_auto;
    logic [W-1:0] q [$];

    always #5 clk = ~clk;

    demultiplexer1_to_4_tdm #(
        .W     (W),
        .ERR_W (ERR_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_din        (din),
        .i_din_valid  (din_valid),
        .i_frame_sync (frame_sync),
        .i_auto_mode  (auto_mode),
        .i_s0         (s0),
        .i_s1         (s1),
        .o_a          (a),
        .o_b          (b),
        .o_c          (c),
        .o_d          (d),
        .o_ch_valid   (ch_valid),
        .o_locked     (locked),
        .o_sync_err   (sync_err),
        .o_err_count  (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit v, input bit fs,
                         input bit am, input bit [1:0] sel,
                         input logic [W-1:0] dv);
        if (rst) begin
            m_out       = '{default: '0};
            m_chv       = 4'b0000;
            m_err       = 1'b0;
            m_cnt       = 0;
            m_locked    = 0;
            m_prev_auto = 0;
            q.delete();
            return;
        end
        m_chv = 4'b0000;
        m_err = 1'b0;
        if (!am) begin
            m_locked = 0;
            q.delete();
            if (v) begin
                m_out[sel] = dv;
                m_chv      = 4'(1 << sel);
            end
        end else begin
            if (!m_prev_auto) begin
                m_locked = 0;
                q.delete();
            end
            if (v) begin
                if (!m_locked) begin
                    if (fs) begin
                        q        = '{dv};
                        m_locked = 1;
                    end
                end else if (fs) begin
                    m_err = (q.size() != 0);
                    q     = '{dv};
                end else if (q.size() == 0) begin
                    m_err    = 1'b1;
                    m_locked = 0;
                end else begin
                    q.push_back(dv);
                    if (q.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_out[i] = q[i];
                        m_chv = 4'b1111;
                        q.delete();
                    end
                end
            end
        end
        if (m_err && m_cnt < (1 << ERR_W) - 1) m_cnt++;
        m_prev_auto = am;
    endtask

    task automatic step(input bit rst, input bit v, input bit fs,
                        input bit am, input bit [1:0] sel,
                        input logic [W-1:0] dv);
        @(negedge clk);
        reset      = rst;
        din_valid  = v;
        frame_sync = fs;
        auto_mode  = am;
        {s1, s0}   = sel;
        din        = dv;
        @(posedge clk);
        model(rst, v, fs, am, sel, dv);
        #1;
        chk("a", 32'(a), 32'(m_out[0]));
        chk("b", 32'(b), 32'(m_out[1]));
        chk("c", 32'(c), 32'(m_out[2]));
        chk("d", 32'(d), 32'(m_out[3]));
        chk("ch_valid", 32'(ch_valid), 32'(m_chv));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("sync_err", 32'(sync_err), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    task automatic idle(input bit am, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, am, 2'd0, 4'hF);
    endtask

    initial begin
        reset = 1'b1; din = '0; din_valid = 0; frame_sync = 0;
        auto_mode = 0; s0 = 0; s1 = 0;
        step(1, 0, 0, 0, 2'd0, 4'h0);
        step(1, 0, 0, 0, 2'd0, 4'h0);
        chk("reset_a", 32'(a), 32'h0);
        chk("reset_locked", 32'(locked), 32'h0);

        // Manual routing
        step(0, 1, 0, 0, 2'd0, 4'h1);
        chk("man_chv0", 32'(ch_valid), 32'h1);
        step(0, 1, 1, 0, 2'd1, 4'h0);
        chk("man_chv1", 32'(ch_valid), 32'h2);
        step(0, 1, 0, 0, 2'd2, 4'h1);
        chk("man_chv2", 32'(ch_valid), 32'h4);
        step(0, 1, 0, 0, 2'd3, 4'h1);
        chk("man_chv3", 32'(ch_valid), 32'h8);
        chk("man_abcd", 32'({a, b, c, d}), 32'h1011);
        idle(0, 1);

        // Auto, back-to-back frame
        step(0, 1, 1, 1, 2'd0, 4'h5);
        step(0, 1, 0, 1, 2'd0, 4'h6);
        step(0, 1, 0, 1, 2'd0, 4'h7);
        chk("auto_nochv", 32'(ch_valid), 32'h0);
        step(0, 1, 0, 1, 2'd0, 4'h8);
        chk("auto_abcd", 32'({a, b, c, d}), 32'h5678);
        chk("auto_chv", 32'(ch_valid), 32'hF);
        chk("auto_lock", 32'(locked), 32'h1);
        idle(1, 1);

        // Auto with gaps
        step(0, 1, 1, 1, 2'd0, 4'h9);
        idle(1, 2);
        step(0, 1, 0, 1, 2'd0, 4'hA);
        idle(1, 2);
        step(0, 1, 0, 1, 2'd0, 4'hB);
        idle(1, 2);
        step(0, 1, 0, 1, 2'd0, 4'hC);
        chk("gap_abcd", 32'({a, b, c, d}), 32'h9ABC);

        // Early sync at slot 2
        step(0, 1, 1, 1, 2'd0, 4'h1);
        step(0, 1, 0, 1, 2'd0, 4'h2);
        step(0, 1, 1, 1, 2'd0, 4'h3);
        chk("early_err", 32'(sync_err), 32'h1);
        chk("early_cnt", 32'(err_count), 32'h1);
        step(0, 1, 0, 1, 2'd0, 4'h4);
        step(0, 1, 0, 1, 2'd0, 4'h5);
        step(0, 1, 0, 1, 2'd0, 4'h6);
        chk("early_abcd", 32'({a, b, c, d}), 32'h3456);

        // Missing sync at slot 0
        step(0, 1, 0, 1, 2'd0, 4'h7);
        chk("miss_err", 32'(sync_err), 32'h1);
        chk("miss_unlock", 32'(locked), 32'h0);

        // Saturation: 257 sync samples give 256 errors
        step(1, 0, 0, 1, 2'd0, 4'h0);
        for (int i = 0; i < 257; i++) step(0, 1, 1, 1, 2'd0, 4'(i));
        chk("sat_cnt", 32'(err_count), 32'd255);

        // Reset mid-frame
        step(0, 1, 0, 1, 2'd0, 4'h1);
        step(0, 1, 1, 1, 2'd0, 4'h2);
        step(1, 1, 0, 1, 2'd0, 4'h3);
        chk("rst_abcd", 32'({a, b, c, d}), 32'h0);
        chk("rst_lock", 32'(locked), 32'h0);

        // Mode toggle mid-frame
        step(0, 1, 1, 1, 2'd0, 4'hE);
        step(0, 1, 0, 1, 2'd0, 4'hD);
        step(0, 1, 0, 0, 2'd2, 4'h4);
        step(0, 1, 0, 1, 2'd0, 4'hC);
        chk("tog_hunt", 32'(locked), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 39) != 0),
                 2'($urandom_range(0, 3)),
                 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
